// File: rtl/issue_scoreboard_pkg.sv
// Shared types and sizes for the dual-issue hazard scoreboard.
package issue_scoreboard_pkg;

  localparam int NREG     = 32;
  localparam int REG_AW   = 5;
  localparam int CNT_W    = 2;
  localparam int IQ_AW    = 4;
  localparam int SB_LANES = 2;

  typedef logic              bool;
  typedef logic [REG_AW-1:0] REG_ADDR;
  typedef logic [IQ_AW-1:0]  IQ_ADDR;
  typedef logic [CNT_W-1:0]  SB_CNT;

  localparam SB_CNT SB_CNT_MAX = '1;

  // True when an enabled write targets a tracked register equal to 'b'.
  function automatic bool tracked_match(input bool en, input REG_ADDR a, input REG_ADDR b);
    return en && (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue-queue head / grant / commit bundle between the issue queue and the scoreboard.
interface issue_scoreboard_if;
  import issue_scoreboard_pkg::*;

  IQ_ADDR                 iq_size;
  REG_ADDR [SB_LANES-1:0] src_a_addr;
  REG_ADDR [SB_LANES-1:0] src_b_addr;
  logic    [SB_LANES-1:0] dst_wena;
  REG_ADDR [SB_LANES-1:0] dst_addr;
  logic    [SB_LANES-1:0] cmt_wena;
  REG_ADDR [SB_LANES-1:0] cmt_waddr;
  logic    [SB_LANES-1:0] issue_valid;
  logic    [1:0]          iq_pop_number;

  modport master (
    output iq_size, src_a_addr, src_b_addr, dst_wena, dst_addr, cmt_wena, cmt_waddr,
    input  issue_valid, iq_pop_number
  );

  modport slave (
    input  iq_size, src_a_addr, src_b_addr, dst_wena, dst_addr, cmt_wena, cmt_waddr,
    output issue_valid, iq_pop_number
  );

endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register in-flight write counter: +inc, -dec, synchronous clear, clamps at 0 on underflow.
module sb_counter
  import issue_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic [1:0] dec,
  output SB_CNT      cnt,
  output logic       underflow
);

  logic [CNT_W:0] sum;
  logic [CNT_W:0] dec_ext;
  logic [CNT_W:0] diff;
  SB_CNT          nxt;

  // Net next value; the grant logic never increments a full counter, so the top clamp is defensive.
  always_comb begin
    sum       = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
    dec_ext   = {{(CNT_W-1){1'b0}}, dec};
    diff      = sum - dec_ext;
    nxt       = diff[CNT_W] ? SB_CNT_MAX : diff[CNT_W-1:0];
    underflow = !clear && (dec_ext > sum);
  end

  // Counter register; clear discards that cycle's decrements entirely.
  always_ff @(posedge clk) begin
    if (!rst || clear)  cnt <= '0;
    else if (underflow) cnt <= '0;
    else                cnt <= nxt;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue hazard scheduler: grants 0/1/2 queue heads against per-register in-flight write counts.
// Optional macro SCOREBOARD_BYPASS_EN: a source whose only in-flight write commits this cycle is ready.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                stall,
  issue_scoreboard_if.slave   iq,
  output logic                sb_busy,
  output logic                sb_error
);

  SB_CNT       cnt [NREG];
  logic [1:0]  dec [1:NREG-1];
  logic [NREG-1:1] inc;
  logic [NREG-1:1] uf;
  REG_ADDR     src [2*SB_LANES];
  logic [2*SB_LANES-1:0] blk;
  logic        go, ok0, ok1, raw, waw;

  assign cnt[0] = '0;
  assign src[0] = iq.src_a_addr[0];
  assign src[1] = iq.src_b_addr[0];
  assign src[2] = iq.src_a_addr[1];
  assign src[3] = iq.src_b_addr[1];

  // Per-source hazard: pending write, optionally forgiven when its last write commits now.
  always_comb begin
    blk = '0;
    for (int unsigned s = 0; s < 2*SB_LANES; s++) begin
      blk[s] = (src[s] != '0) && (cnt[src[s]] != '0);
`ifdef SCOREBOARD_BYPASS_EN
      if (blk[s] && (cnt[src[s]] == SB_CNT'(1)) &&
          ((iq.cmt_wena[0] && iq.cmt_waddr[0] == src[s]) ||
           (iq.cmt_wena[1] && iq.cmt_waddr[1] == src[s])))
        blk[s] = 1'b0;
`endif
    end
  end

  // Grant: slot1 only follows slot0; intra-pair RAW/WAW use the raw addresses, never the bypass.
  always_comb begin
    go  = rst && !flush && !stall;
    raw = tracked_match(iq.dst_wena[0], iq.dst_addr[0], iq.src_a_addr[1]) ||
          tracked_match(iq.dst_wena[0], iq.dst_addr[0], iq.src_b_addr[1]);
    waw = iq.dst_wena[1] && tracked_match(iq.dst_wena[0], iq.dst_addr[0], iq.dst_addr[1]);
    ok0 = go && (iq.iq_size != '0) && !blk[0] && !blk[1] &&
          !(iq.dst_wena[0] && cnt[iq.dst_addr[0]] == SB_CNT_MAX);
    ok1 = ok0 && (iq.iq_size > IQ_ADDR'(1)) && !blk[2] && !blk[3] &&
          !(iq.dst_wena[1] && cnt[iq.dst_addr[1]] == SB_CNT_MAX) && !raw && !waw;
    iq.issue_valid   = {ok1, ok0};
    iq.iq_pop_number = ok1 ? 2'd2 : (ok0 ? 2'd1 : 2'd0);
  end

  // Per-register increment from issued writers and decrement from commit lanes.
  always_comb begin
    inc = '0;
    dec = '{default: '0};
    for (int unsigned r = 1; r < NREG; r++) begin
      for (int unsigned k = 0; k < SB_LANES; k++) begin
        if (iq.issue_valid[k] && iq.dst_wena[k] && iq.dst_addr[k] == REG_ADDR'(r))
          inc[r] = 1'b1;
        if (iq.cmt_wena[k] && iq.cmt_waddr[k] == REG_ADDR'(r))
          dec[r] = dec[r] + 2'd1;
      end
    end
  end

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .cnt       (cnt[r]),
      .underflow (uf[r])
    );
  end

  // Busy whenever any tracked register has an in-flight write.
  always_comb begin
    sb_busy = 1'b0;
    for (int unsigned r = 1; r < NREG; r++)
      if (cnt[r] != '0) sb_busy = 1'b1;
  end

  // Sticky underflow flag; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst)      sb_error <= 1'b0;
    else if (|uf)  sb_error <= 1'b1;
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: table of single-cycle grant vectors plus hazard sequences.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, stall;
  logic sb_busy, sb_error;

  issue_scoreboard_if bus ();

  issue_scoreboard dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .iq       (bus),
    .sb_busy  (sb_busy),
    .sb_error (sb_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q [$];

  typedef struct {
    int   size;
    int   sa0, sb0; bit dw0; int d0;
    int   sa1, sb1; bit dw1; int d1;
    bit   st;
    logic [1:0] iv;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nonzero_cnts();
    int n = 0;
    for (int r = 1; r < NREG; r++)
      if (dut.cnt[r] != '0) n++;
    return n;
  endfunction

  task automatic idle();
    bus.iq_size    = '0;
    bus.src_a_addr = '0;
    bus.src_b_addr = '0;
    bus.dst_wena   = '0;
    bus.dst_addr   = '0;
    bus.cmt_wena   = '0;
    bus.cmt_waddr  = '0;
    flush = 1'b0;
    stall = 1'b0;
  endtask

  task automatic head(input int k, input int sa, input int sb, input bit dw, input int d);
    bus.src_a_addr[k] = REG_ADDR'(sa);
    bus.src_b_addr[k] = REG_ADDR'(sb);
    bus.dst_wena[k]   = dw;
    bus.dst_addr[k]   = REG_ADDR'(d);
  endtask

  task automatic cmt(input logic [1:0] w, input int a0, input int a1);
    bus.cmt_wena     = w;
    bus.cmt_waddr[0] = REG_ADDR'(a0);
    bus.cmt_waddr[1] = REG_ADDR'(a1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected grant, wait to the opposite edge, compare against the queue head.
  task automatic grant(input string name, input logic [1:0] iv);
    logic [1:0] e;
    exp_q.push_back(iv);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".valid"}, int'(bus.issue_valid), int'(e));
      chk({name, ".pop"}, int'(bus.iq_pop_number), int'(e[0]) + int'(e[1]));
    end
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1, 2, 1, 3, 5, 6, 1, 4, 0, 2'b00};  // empty queue
    tbl[1] = '{1, 1, 2, 1, 3, 5, 6, 1, 4, 0, 2'b01};  // single entry
    tbl[2] = '{2, 1, 2, 1, 3, 5, 6, 1, 4, 0, 2'b11};  // independent pair
    tbl[3] = '{2, 1, 2, 1, 5, 6, 5, 1, 4, 0, 2'b01};  // RAW on src_b
    tbl[4] = '{2, 1, 2, 1, 5, 6, 7, 1, 5, 0, 2'b01};  // WAW
    tbl[5] = '{2, 1, 2, 1, 0, 6, 7, 1, 0, 0, 2'b11};  // both write r0
    tbl[6] = '{2, 1, 2, 1, 0, 0, 0, 1, 4, 0, 2'b11};  // slot1 reads r0 written by slot0
    tbl[7] = '{2, 1, 2, 0, 5, 5, 7, 1, 4, 0, 2'b11};  // no slot0 write, same addr
    tbl[8] = '{2, 1, 2, 1, 3, 5, 6, 1, 4, 1, 2'b00};  // stall
    tbl[9] = '{15, 1, 2, 1, 3, 5, 6, 1, 4, 0, 2'b11}; // deep queue

    // Reset with a full-looking queue
    idle();
    rst = 1'b0;
    bus.iq_size = IQ_ADDR'(4);
    head(0, 1, 2, 1, 3);
    head(1, 5, 6, 1, 4);
    for (int i = 0; i < 2; i++) begin
      grant("reset_grant", 2'b00);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    chk("reset_cnts", nonzero_cnts(), 0);
    chk("reset_busy", int'(sb_busy), 0);
    chk("reset_error", int'(sb_error), 0);

    // Single-cycle vectors from an empty scoreboard
    for (int i = 0; i < 10; i++) begin
      idle();
      bus.iq_size = IQ_ADDR'(tbl[i].size);
      head(0, tbl[i].sa0, tbl[i].sb0, tbl[i].dw0, tbl[i].d0);
      head(1, tbl[i].sa1, tbl[i].sb1, tbl[i].dw1, tbl[i].d1);
      stall = tbl[i].st;
      grant($sformatf("vec%0d", i), tbl[i].iv);
      tick();
      do_flush();
    end
    chk("vec_busy_after_flush", int'(sb_busy), 0);

    // Independent pair
    idle();
    bus.iq_size = IQ_ADDR'(2);
    head(0, 1, 2, 1, 3);
    head(1, 5, 6, 1, 4);
    grant("pair", 2'b11);
    tick();
    chk("pair_cnt3", int'(dut.cnt[3]), 1);
    chk("pair_cnt4", int'(dut.cnt[4]), 1);
    chk("pair_busy", int'(sb_busy), 1);
    do_flush();

    // Intra-pair RAW then commit of the producer
    bus.iq_size = IQ_ADDR'(2);
    head(0, 1, 2, 1, 3);
    head(1, 3, 0, 1, 10);
    grant("raw_pair", 2'b01);
    tick();
    idle();
    bus.iq_size = IQ_ADDR'(1);
    head(0, 3, 0, 1, 10);
    grant("raw_wait", 2'b00);
    tick();
    cmt(2'b01, 3, 0);
`ifdef SCOREBOARD_BYPASS_EN
    grant("raw_commit", 2'b01);
`else
    grant("raw_commit", 2'b00);
`endif
    tick();
    chk("raw_cnt3", int'(dut.cnt[3]), 0);
`ifndef SCOREBOARD_BYPASS_EN
    cmt(2'b00, 0, 0);
    grant("raw_after", 2'b01);
    tick();
`endif
    chk("raw_cnt10", int'(dut.cnt[10]), 1);
    do_flush();

    // Saturation on r7
    bus.iq_size = IQ_ADDR'(1);
    head(0, 0, 0, 1, 7);
    for (int i = 0; i < 3; i++) begin
      grant("sat_fill", 2'b01);
      tick();
    end
    chk("sat_cnt7_full", int'(dut.cnt[7]), 3);
    grant("sat_block", 2'b00);
    tick();
    cmt(2'b01, 7, 0);
    grant("sat_block_cmt", 2'b00);
    tick();
    chk("sat_cnt7_after_cmt", int'(dut.cnt[7]), 2);
    grant("sat_inc_dec", 2'b01);
    tick();
    chk("sat_cnt7_net", int'(dut.cnt[7]), 2);
    cmt(2'b00, 0, 0);
    grant("sat_refill", 2'b01);
    tick();
    chk("sat_cnt7_refull", int'(dut.cnt[7]), 3);
    do_flush();

    // Flush mid-flight, discarded commits must not underflow
    bus.iq_size = IQ_ADDR'(2);
    head(0, 0, 0, 1, 3);
    head(1, 0, 0, 1, 9);
    grant("fl_pair", 2'b11);
    tick();
    bus.iq_size = IQ_ADDR'(1);
    grant("fl_single", 2'b01);
    tick();
    chk("fl_cnt3", int'(dut.cnt[3]), 2);
    chk("fl_cnt9", int'(dut.cnt[9]), 1);
    bus.iq_size = IQ_ADDR'(2);
    head(0, 1, 2, 1, 5);
    head(1, 6, 11, 1, 4);
    cmt(2'b11, 9, 12);
    flush = 1'b1;
    grant("fl_grant", 2'b00);
    tick();
    idle();
    chk("fl_cnts", nonzero_cnts(), 0);
    chk("fl_busy", int'(sb_busy), 0);
    chk("fl_error", int'(sb_error), 0);

    // Dual commit to the same register, then underflow
    bus.iq_size = IQ_ADDR'(1);
    head(0, 0, 0, 1, 8);
    grant("dc_fill0", 2'b01);
    tick();
    grant("dc_fill1", 2'b01);
    tick();
    chk("dc_cnt8", int'(dut.cnt[8]), 2);
    idle();
    cmt(2'b11, 8, 8);
    grant("dc_commit", 2'b00);
    tick();
    chk("dc_cnt8_zero", int'(dut.cnt[8]), 0);
    chk("dc_error_clean", int'(sb_error), 0);
    cmt(2'b01, 8, 0);
    tick();
    idle();
    chk("dc_error_set", int'(sb_error), 1);
    chk("dc_cnt8_clamp", int'(dut.cnt[8]), 0);
    tick();
    tick();
    chk("dc_error_sticky", int'(sb_error), 1);
    chk("dc_busy", int'(sb_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
